// File: rtl/btb_update_queue_pkg.sv
// Shared types and helpers for the BTB update queue: the queued write record,
// the branch-type and counter encodings, and the 2-bit saturating counter step.
package btb_update_queue_pkg;

    localparam logic [1:0] BR_COND       = 2'b00;
    localparam logic [1:0] BR_JUMP       = 2'b10;
    localparam logic [1:0] CNTR_WEAK_T   = 2'b10;
    localparam logic [1:0] CNTR_STRONG_T = 2'b11;

    typedef struct packed {
        logic [29:0] vpc;
        logic [29:0] target;
        logic [1:0]  cntr;
        logic [1:0]  br_type;
        logic        way;
        logic        alloc;
    } btb_upd_t;

    function automatic logic [1:0] sat2_update(input logic [1:0] cntr, input logic taken);
        logic [1:0] res;
        res = cntr;
        if (taken) begin
            if (cntr != 2'b11) res = cntr + 2'd1;
        end else begin
            if (cntr != 2'b00) res = cntr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_update_queue_if.sv
// BTB write-port bundle: valid/ready handshake plus the packed write record.
// The queue drives it as master; the BTB write port is the slave.
interface btb_update_queue_if;
    import btb_update_queue_pkg::*;

    logic     btb_wr_vld;
    logic     btb_wr_rdy;
    btb_upd_t btb_wr_dat;

    modport master (output btb_wr_vld, output btb_wr_dat, input  btb_wr_rdy);
    modport slave  (input  btb_wr_vld, input  btb_wr_dat, output btb_wr_rdy);

endinterface

// File: rtl/btb_update_queue_fifo.sv
// DEPTH-entry ring of btb_upd_t records with full/empty flags and an occupancy count.
// Head is read combinationally; push is ignored when full unless a pop frees a slot the same edge.
module btb_upd_fifo
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  btb_upd_t push_dat_i,
    input  logic     pop_i,
    output btb_upd_t head_dat_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    btb_upd_t          mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign pop_ok     = pop_i & ~empty_o;
    assign push_ok    = push_i & (~full_o | pop_ok);
    assign head_dat_o = mem_q[rd_ptr_q];

    // Power-of-two DEPTH lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop_ok) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/btb_update_queue.sv
// Turns resolved-branch outcomes into BTB/bimodal write requests, buffered in a DEPTH-entry FIFO.
// Latency 1 cycle through the FIFO; 0 cycles when BTB_UPD_BYPASS_EN is defined and the queue is empty with ready high.
// Drains one write per cycle with btb_wr_rdy high; a qualifying update arriving full with no pop is dropped (upd_drop_o).
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_ni,
    input  logic        c1_valid_i,
    input  logic        c1_excp_i,
    input  logic        c1_bm_mod_i,
    input  logic        c1_btb_hit_i,
    input  logic [29:0] c1_btb_vpc_i,
    input  logic [31:0] c1_btb_target_i,
    input  logic [1:0]  c1_cntr_pred_i,
    input  logic        c1_bnch_tkn_i,
    input  logic [1:0]  c1_bnch_type_i,
    input  logic        c1_btb_way_i,
    btb_update_queue_if.master btb_wr,
    output logic        upd_drop_o
);

    btb_upd_t upd;
    btb_upd_t head_dat;
    logic     need, req_vld, is_cond;
    logic     fifo_full, fifo_empty;
    logic     push, pop, byp;
    logic     victim_q, victim_d;
    logic     drop_q, drop_d;
    logic     unused_tgt_lsb;

    assign unused_tgt_lsb = ^c1_btb_target_i[1:0];

    assign need    = c1_valid_i & (c1_excp_i | c1_bm_mod_i);
    // A not-taken miss has nothing worth allocating.
    assign req_vld = need & (c1_btb_hit_i | c1_bnch_tkn_i);
    assign is_cond = (c1_bnch_type_i == BR_COND);

    always_comb begin
        upd         = '0;
        upd.vpc     = c1_btb_vpc_i;
        upd.target  = c1_btb_target_i[31:2];
        upd.br_type = c1_bnch_type_i;
        if (c1_btb_hit_i) begin
            upd.alloc = 1'b0;
            upd.way   = c1_btb_way_i;
            upd.cntr  = is_cond ? sat2_update(c1_cntr_pred_i, c1_bnch_tkn_i) : CNTR_STRONG_T;
        end else begin
            upd.alloc = 1'b1;
            upd.way   = victim_q;
            upd.cntr  = is_cond ? CNTR_WEAK_T : CNTR_STRONG_T;
        end
    end

`ifdef BTB_UPD_BYPASS_EN
    assign byp = fifo_empty & req_vld & btb_wr.btb_wr_rdy;
`else
    assign byp = 1'b0;
`endif

    assign pop  = ~fifo_empty & btb_wr.btb_wr_rdy;
    assign push = req_vld & ~byp & (~fifo_full | pop);

    assign btb_wr.btb_wr_vld = ~fifo_empty | byp;
    assign btb_wr.btb_wr_dat = byp ? upd : head_dat;
    assign upd_drop_o        = drop_q;

    always_comb begin
        drop_d   = req_vld & ~byp & fifo_full & ~pop;
        victim_d = victim_q ^ (upd.alloc & (push | byp));
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            victim_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            victim_q <= victim_d;
            drop_q   <= drop_d;
        end
    end

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (cpu_clock_i),
        .rst_ni     (cpu_reset_ni),
        .push_i     (push),
        .push_dat_i (upd),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule
